reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo core.
- Allocates a reorder tag per decoded instruction and captures results from the CDB (common data bus).
- Forwards ready results to the decoder by tag.
- Retires one instruction per cycle to the register file, or releases one store to the LSB (load/store buffer).
- Raises the pipeline flush on a mispredicted control transfer. It drives the register file's commit and flush inputs.

Parameters:
ROB_ADDR_W, 4, tag width; depth = 2**ROB_ADDR_W (16).
DATA_W, 32, result/PC width.
REG_W, 5, architectural register index width.

Ports:
in_clk  input  1  clock
in_rst  input  1  synchronous active-high reset
in_rdy  input  1  global enable; state frozen when 0
in_decoder_enable  input  1  allocate one entry this cycle
in_decoder_rd  input  REG_W  destination register of new entry
in_decoder_is_store  input  1  new entry is a store (no register write)
out_decoder_full  output  1  no free entry
out_decoder_reorder  output  ROB_ADDR_W  tag the next allocation will receive (tail)
in_decoder_rs_reorder  input  ROB_ADDR_W  operand-1 tag query
in_decoder_rt_reorder  input  ROB_ADDR_W  operand-2 tag query
out_decoder_rs_ready  output  1  operand-1 result available
out_decoder_rs_value  output  DATA_W  operand-1 result
out_decoder_rt_ready  output  1  operand-2 result available
out_decoder_rt_value  output  DATA_W  operand-2 result
in_cdb_enable  input  1  result broadcast valid
in_cdb_reorder  input  ROB_ADDR_W  producing tag
in_cdb_value  input  DATA_W  result value (link address for jumps)
in_cdb_mispredict  input  1  control transfer mispredicted
in_cdb_target_pc  input  DATA_W  correct next PC
out_reg_commit_enable  output  1  register-file write this cycle
out_reg_rd_addr  output  REG_W  committed rd
out_reg_rd_value  output  DATA_W  committed value
out_reg_reorder  output  ROB_ADDR_W  committed tag (head)
out_lsb_store_commit  output  1  head store may write memory
out_lsb_reorder  output  ROB_ADDR_W  tag of released store
out_flush_enable  output  1  squash all speculative state
out_flush_pc  output  DATA_W  fetch redirect PC

Behaviour:
- Storage: per entry busy, ready, is_store, mispredict, rd, value, target_pc.
- Pointers: head, tail (ROB_ADDR_W, wrap naturally); count is ROB_ADDR_W+1 bits.
- Reset: head = tail = count = 0 and all busy/ready cleared. Every output is 0 except out_decoder_reorder = 0.
- in_rdy = 0: no state change. Combinational outputs still track state but all pulse outputs (commit, store_commit, flush) are gated to 0.
- out_decoder_full = (count == 2**ROB_ADDR_W). It reflects registered count; a commit in the same cycle does not unblock allocation.
- Allocation (enable && !full && !flush): entry[tail] <= {busy=1, ready=0, rd, is_store, mispredict=0}; tail++. An allocation request while full or while flushing is dropped.
- CDB write: if entry[in_cdb_reorder].busy, it sets ready=1 and stores value, mispredict and target_pc at the edge. A write to a non-busy tag is ignored.
- Operand query (combinational): rs_ready = busy[tag] && (ready[tag] || (in_cdb_enable && in_cdb_reorder == tag)). Value comes from the CDB on a bypass hit, else from the entry. rt is identical.
- Commit is combinational from head, so the register file and the ROB update on the same edge.
- Commit condition: valid = in_rdy && count != 0 && ready[head]. Only the head is examined; at most one retire per cycle.
- Non-store head: out_reg_commit_enable = 1 with rd, value and out_reg_reorder = head. rd = 0 is passed through; the register file discards it.
- Store head: out_lsb_store_commit = 1, out_lsb_reorder = head; out_reg_commit_enable = 0.
- Mispredicted head: commits like a non-store (link write) plus out_flush_enable = 1, out_flush_pc = target_pc. At the edge all entries clear and head = tail = count = 0.
- Retire without flush: busy[head] <= 0; head++.
- Count update: count += alloc − retire.
- A CDB write to the head in the same cycle does not commit that cycle; the head commits the following cycle.
- Wrap-around: tag 15 is followed by tag 0, with no reserved tag.

Test Plan:
- Reset, then allocate rd 5,6,7 on three cycles -> tags 0,1,2 returned; count = 3; no commit pulses.
- CDB tag1 = 0x11, next cycle tag0 = 0x22 -> no commit until the cycle after the tag0 write. Then commit rd5/0x22/tag0, next cycle rd6/0x11/tag1.
- Allocate 16 entries -> full = 1 and the 17th allocation is dropped. Commit head while allocating -> allocation still dropped, full = 0 next cycle, tail wraps to 0.
- Query rs tag3 while CDB broadcasts tag3 = 0xDEAD -> rs_ready = 1 and rs_value = 0xDEAD in the same cycle; rt on an unwritten tag -> ready = 0.
- Jump at tag2: rd1, value 0x104, mispredict, target 0x200, with allocation requested in the commit cycle -> commit rd1/0x104, flush = 1, flush_pc = 0x200. Next cycle count = 0 and out_decoder_reorder = 0; the allocation is dropped.
- Store at head ready with in_rdy = 0 -> no pulses. Raise in_rdy -> one-cycle out_lsb_store_commit with its tag; out_reg_commit_enable stays 0.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Bundles the ROB's decoder, CDB, register-file, LSB and flush signals.
// The slave modport is the ROB side; the master modport is the surrounding core.
interface reorder_buffer_if #(
  parameter int unsigned ROB_ADDR_W = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5
);
  // Decoder allocation
  logic                  in_decoder_enable;
  logic [REG_W-1:0]      in_decoder_rd;
  logic                  in_decoder_is_store;
  logic                  out_decoder_full;
  logic [ROB_ADDR_W-1:0] out_decoder_reorder;
  // Decoder operand queries
  logic [ROB_ADDR_W-1:0] in_decoder_rs_reorder;
  logic [ROB_ADDR_W-1:0] in_decoder_rt_reorder;
  logic                  out_decoder_rs_ready;
  logic [DATA_W-1:0]     out_decoder_rs_value;
  logic                  out_decoder_rt_ready;
  logic [DATA_W-1:0]     out_decoder_rt_value;
  // Common data bus
  logic                  in_cdb_enable;
  logic [ROB_ADDR_W-1:0] in_cdb_reorder;
  logic [DATA_W-1:0]     in_cdb_value;
  logic                  in_cdb_mispredict;
  logic [DATA_W-1:0]     in_cdb_target_pc;
  // Register-file commit
  logic                  out_reg_commit_enable;
  logic [REG_W-1:0]      out_reg_rd_addr;
  logic [DATA_W-1:0]     out_reg_rd_value;
  logic [ROB_ADDR_W-1:0] out_reg_reorder;
  // Store release and flush
  logic                  out_lsb_store_commit;
  logic [ROB_ADDR_W-1:0] out_lsb_reorder;
  logic                  out_flush_enable;
  logic [DATA_W-1:0]     out_flush_pc;

  modport slave (
    input  in_decoder_enable, in_decoder_rd, in_decoder_is_store,
    input  in_decoder_rs_reorder, in_decoder_rt_reorder,
    input  in_cdb_enable, in_cdb_reorder, in_cdb_value, in_cdb_mispredict, in_cdb_target_pc,
    output out_decoder_full, out_decoder_reorder,
    output out_decoder_rs_ready, out_decoder_rs_value,
    output out_decoder_rt_ready, out_decoder_rt_value,
    output out_reg_commit_enable, out_reg_rd_addr, out_reg_rd_value, out_reg_reorder,
    output out_lsb_store_commit, out_lsb_reorder, out_flush_enable, out_flush_pc
  );

  modport master (
    output in_decoder_enable, in_decoder_rd, in_decoder_is_store,
    output in_decoder_rs_reorder, in_decoder_rt_reorder,
    output in_cdb_enable, in_cdb_reorder, in_cdb_value, in_cdb_mispredict, in_cdb_target_pc,
    input  out_decoder_full, out_decoder_reorder,
    input  out_decoder_rs_ready, out_decoder_rs_value,
    input  out_decoder_rt_ready, out_decoder_rt_value,
    input  out_reg_commit_enable, out_reg_rd_addr, out_reg_rd_value, out_reg_reorder,
    input  out_lsb_store_commit, out_lsb_reorder, out_flush_enable, out_flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at the tail, captures CDB results,
// forwards ready operands, and retires/flushes from the head one entry per cycle.
module reorder_buffer #(
  parameter int unsigned ROB_ADDR_W = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_rdy,
  reorder_buffer_if.slave  bus
);
  localparam int unsigned Depth = 2 ** ROB_ADDR_W;

  logic [Depth-1:0]      busy_q, busy_d;
  logic [Depth-1:0]      ready_q, ready_d;
  logic [Depth-1:0]      is_store_q, is_store_d;
  logic [Depth-1:0]      mispredict_q, mispredict_d;
  logic [REG_W-1:0]      rd_q [Depth];
  logic [REG_W-1:0]      rd_d [Depth];
  logic [DATA_W-1:0]     value_q [Depth];
  logic [DATA_W-1:0]     value_d [Depth];
  logic [DATA_W-1:0]     target_q [Depth];
  logic [DATA_W-1:0]     target_d [Depth];
  logic [ROB_ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_ADDR_W:0]   count_q, count_d;

  logic full, commit_valid, flush, reg_commit, store_commit, alloc, retire, cdb_wr;
  logic rs_hit, rt_hit, rs_ready, rt_ready;

  // Head retirement decode and the per-cycle actions, all qualified by the global enable.
  always_comb begin
    full         = (count_q == (ROB_ADDR_W + 1)'(Depth));
    commit_valid = in_rdy && (count_q != '0) && ready_q[head_q];
    flush        = commit_valid && mispredict_q[head_q];
    reg_commit   = commit_valid && !is_store_q[head_q];
    store_commit = commit_valid && is_store_q[head_q];
    // Full is the registered count, so a same-cycle retire does not admit an allocation.
    alloc        = in_rdy && bus.in_decoder_enable && !full && !flush;
    retire       = commit_valid && !flush;
    cdb_wr       = in_rdy && bus.in_cdb_enable && busy_q[bus.in_cdb_reorder];
  end

  // Next-state for storage and pointers; a flush overrides everything.
  always_comb begin
    busy_d       = busy_q;
    ready_d      = ready_q;
    is_store_d   = is_store_q;
    mispredict_d = mispredict_q;
    rd_d         = rd_q;
    value_d      = value_q;
    target_d     = target_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    if (cdb_wr) begin
      ready_d[bus.in_cdb_reorder]      = 1'b1;
      value_d[bus.in_cdb_reorder]      = bus.in_cdb_value;
      mispredict_d[bus.in_cdb_reorder] = bus.in_cdb_mispredict;
      target_d[bus.in_cdb_reorder]     = bus.in_cdb_target_pc;
    end
    if (alloc) begin
      busy_d[tail_q]       = 1'b1;
      ready_d[tail_q]      = 1'b0;
      mispredict_d[tail_q] = 1'b0;
      is_store_d[tail_q]   = bus.in_decoder_is_store;
      rd_d[tail_q]         = bus.in_decoder_rd;
      tail_d               = tail_q + 1'b1;
    end
    if (retire) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    unique case ({alloc, retire})
      2'b10:   count_d = count_q + (ROB_ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ROB_ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      busy_d       = '0;
      ready_d      = '0;
      mispredict_d = '0;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      busy_q       <= '0;
      ready_q      <= '0;
      is_store_q   <= '0;
      mispredict_q <= '0;
      rd_q         <= '{default: '0};
      value_q      <= '{default: '0};
      target_q     <= '{default: '0};
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      is_store_q   <= is_store_d;
      mispredict_q <= mispredict_d;
      rd_q         <= rd_d;
      value_q      <= value_d;
      target_q     <= target_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  // Operand forwarding with same-cycle CDB bypass; values read as 0 when not ready.
  always_comb begin
    rs_hit   = bus.in_cdb_enable && (bus.in_cdb_reorder == bus.in_decoder_rs_reorder);
    rt_hit   = bus.in_cdb_enable && (bus.in_cdb_reorder == bus.in_decoder_rt_reorder);
    rs_ready = busy_q[bus.in_decoder_rs_reorder] && (ready_q[bus.in_decoder_rs_reorder] || rs_hit);
    rt_ready = busy_q[bus.in_decoder_rt_reorder] && (ready_q[bus.in_decoder_rt_reorder] || rt_hit);
    bus.out_decoder_rs_ready = rs_ready;
    bus.out_decoder_rt_ready = rt_ready;
    bus.out_decoder_rs_value = '0;
    bus.out_decoder_rt_value = '0;
    if (rs_ready) begin
      bus.out_decoder_rs_value = rs_hit ? bus.in_cdb_value : value_q[bus.in_decoder_rs_reorder];
    end
    if (rt_ready) begin
      bus.out_decoder_rt_value = rt_hit ? bus.in_cdb_value : value_q[bus.in_decoder_rt_reorder];
    end
  end

  // Commit, store-release and flush outputs driven straight from the head entry.
  always_comb begin
    bus.out_decoder_full      = full;
    bus.out_decoder_reorder   = tail_q;
    bus.out_reg_commit_enable = reg_commit;
    bus.out_reg_rd_addr       = reg_commit ? rd_q[head_q] : '0;
    bus.out_reg_rd_value      = reg_commit ? value_q[head_q] : '0;
    bus.out_reg_reorder       = head_q;
    bus.out_lsb_store_commit  = store_commit;
    bus.out_lsb_reorder       = head_q;
    bus.out_flush_enable      = flush;
    bus.out_flush_pc          = flush ? target_q[head_q] : '0;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued when results are
// broadcast and compared against the commit/store/flush pulses as they appear.
module tb_reorder_buffer;
  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  logic in_rdy = 1'b0;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .in_rdy (in_rdy),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    bit          st;
    bit          fl;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  tag;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
  } pend_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Retirement monitor: every pulse must match the oldest expected retirement.
  always @(negedge in_clk) begin
    if (!in_rst && (bus.out_reg_commit_enable || bus.out_lsb_store_commit ||
                    bus.out_flush_enable)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_retire reg=%0b st=%0b fl=%0b tag=%0d required none",
                 bus.out_reg_commit_enable, bus.out_lsb_store_commit, bus.out_flush_enable,
                 bus.out_reg_reorder);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.st) begin
          if (bus.out_lsb_store_commit !== 1'b1 || bus.out_reg_commit_enable !== 1'b0 ||
              bus.out_flush_enable !== 1'b0 || bus.out_lsb_reorder !== e.tag) begin
            errors++;
            $display("FAIL store_retire st=%0b reg=%0b fl=%0b tag=%0d required st=1 tag=%0d",
                     bus.out_lsb_store_commit, bus.out_reg_commit_enable,
                     bus.out_flush_enable, bus.out_lsb_reorder, e.tag);
          end
        end else begin
          if (bus.out_reg_commit_enable !== 1'b1 || bus.out_lsb_store_commit !== 1'b0 ||
              bus.out_reg_rd_addr !== e.rd || bus.out_reg_rd_value !== e.val ||
              bus.out_reg_reorder !== e.tag || bus.out_flush_enable !== e.fl ||
              (e.fl && bus.out_flush_pc !== e.pc)) begin
            errors++;
            $display("FAIL reg_retire rd=%0d val=%h tag=%0d fl=%0b pc=%h required rd=%0d val=%h tag=%0d fl=%0b pc=%h",
                     bus.out_reg_rd_addr, bus.out_reg_rd_value, bus.out_reg_reorder,
                     bus.out_flush_enable, bus.out_flush_pc, e.rd, e.val, e.tag, e.fl, e.pc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_decoder_enable     = 1'b0;
    bus.in_decoder_rd         = '0;
    bus.in_decoder_is_store   = 1'b0;
    bus.in_decoder_rs_reorder = '0;
    bus.in_decoder_rt_reorder = '0;
    bus.in_cdb_enable         = 1'b0;
    bus.in_cdb_reorder        = '0;
    bus.in_cdb_value          = '0;
    bus.in_cdb_mispredict     = 1'b0;
    bus.in_cdb_target_pc      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    in_rst = 1'b1;
    in_rdy = 1'b0;
    exp_q.delete();
    tick();
    tick();
    in_rst = 1'b0;
    in_rdy = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] rd, input bit st);
    bus.in_decoder_enable   = 1'b1;
    bus.in_decoder_rd       = rd;
    bus.in_decoder_is_store = st;
    tick();
    bus.in_decoder_enable   = 1'b0;
    bus.in_decoder_is_store = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input bit mp,
                     input logic [31:0] pc);
    bus.in_cdb_enable     = 1'b1;
    bus.in_cdb_reorder    = tag;
    bus.in_cdb_value      = val;
    bus.in_cdb_mispredict = mp;
    bus.in_cdb_target_pc  = pc;
  endtask

  task automatic cdb_off();
    bus.in_cdb_enable     = 1'b0;
    bus.in_cdb_mispredict = 1'b0;
  endtask

  task automatic push_reg(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] tag);
    exp_t e;
    e = '{st: 1'b0, fl: 1'b0, rd: rd, val: val, tag: tag, pc: 32'h0};
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (bus.out_decoder_full !== 1'b0 || bus.out_decoder_reorder !== 4'd0 ||
        bus.out_reg_commit_enable !== 1'b0 || bus.out_lsb_store_commit !== 1'b0 ||
        bus.out_flush_enable !== 1'b0 || bus.out_decoder_rs_ready !== 1'b0 ||
        bus.out_reg_rd_value !== 32'h0 || bus.out_flush_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs full=%0b tag=%0d reg=%0b st=%0b fl=%0b rs=%0b required all 0",
               bus.out_decoder_full, bus.out_decoder_reorder, bus.out_reg_commit_enable,
               bus.out_lsb_store_commit, bus.out_flush_enable, bus.out_decoder_rs_ready);
    end
  endtask

  task automatic test_alloc();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_decoder_reorder !== 4'(i)) begin
        errors++;
        $display("FAIL alloc_tag got=%0d required %0d", bus.out_decoder_reorder, i);
      end
      alloc(5'(5 + i), 1'b0);
    end
    checks++;
    if (bus.out_decoder_reorder !== 4'd3 || bus.out_decoder_full !== 1'b0) begin
      errors++;
      $display("FAIL alloc_tail got=%0d full=%0b required 3 full=0",
               bus.out_decoder_reorder, bus.out_decoder_full);
    end
  endtask

  task automatic test_cdb_order();
    // Continues from test_alloc: tags 0,1,2 hold rd 5,6,7.
    cdb(4'd1, 32'h11, 1'b0, 32'h0);
    tick();
    cdb(4'd0, 32'h22, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.out_reg_commit_enable !== 1'b0) begin
      errors++;
      $display("FAIL cdb_head_same_cycle commit=%0b required 0", bus.out_reg_commit_enable);
    end
    push_reg(5'd5, 32'h22, 4'd0);
    push_reg(5'd6, 32'h11, 4'd1);
    tick();
    cdb_off();
    #1;
    checks++;
    if (bus.out_reg_commit_enable !== 1'b1 || bus.out_reg_reorder !== 4'd0) begin
      errors++;
      $display("FAIL cdb_head_next_cycle commit=%0b tag=%0d required 1 tag=0",
               bus.out_reg_commit_enable, bus.out_reg_reorder);
    end
    drain("cdb_order");
    checks++;
    if (bus.out_reg_reorder !== 4'd2 || bus.out_reg_commit_enable !== 1'b0) begin
      errors++;
      $display("FAIL cdb_order_head head=%0d commit=%0b required head=2 commit=0",
               bus.out_reg_reorder, bus.out_reg_commit_enable);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) alloc(5'(i), 1'b0);
    checks++;
    if (bus.out_decoder_full !== 1'b1 || bus.out_decoder_reorder !== 4'd0) begin
      errors++;
      $display("FAIL full_set full=%0b tail=%0d required full=1 tail=0",
               bus.out_decoder_full, bus.out_decoder_reorder);
    end
    alloc(5'd20, 1'b0);
    checks++;
    if (bus.out_decoder_full !== 1'b1 || bus.out_decoder_reorder !== 4'd0) begin
      errors++;
      $display("FAIL full_drop full=%0b tail=%0d required full=1 tail=0",
               bus.out_decoder_full, bus.out_decoder_reorder);
    end
    // Make head ready, then commit it while an allocation is requested.
    cdb(4'd0, 32'hAA, 1'b0, 32'h0);
    push_reg(5'd0, 32'hAA, 4'd0);
    tick();
    cdb_off();
    bus.in_decoder_enable = 1'b1;
    bus.in_decoder_rd     = 5'd21;
    #1;
    checks++;
    if (bus.out_reg_commit_enable !== 1'b1 || bus.out_decoder_full !== 1'b1) begin
      errors++;
      $display("FAIL full_commit commit=%0b full=%0b required commit=1 full=1",
               bus.out_reg_commit_enable, bus.out_decoder_full);
    end
    tick();
    bus.in_decoder_enable = 1'b0;
    checks++;
    if (bus.out_decoder_full !== 1'b0 || bus.out_decoder_reorder !== 4'd0) begin
      errors++;
      $display("FAIL full_release full=%0b tail=%0d required full=0 tail=0",
               bus.out_decoder_full, bus.out_decoder_reorder);
    end
    alloc(5'd22, 1'b0);
    checks++;
    if (bus.out_decoder_full !== 1'b1 || bus.out_decoder_reorder !== 4'd1) begin
      errors++;
      $display("FAIL full_wrap full=%0b tail=%0d required full=1 tail=1",
               bus.out_decoder_full, bus.out_decoder_reorder);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b0);
    bus.in_decoder_rs_reorder = 4'd3;
    bus.in_decoder_rt_reorder = 4'd1;
    cdb(4'd3, 32'hDEAD, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.out_decoder_rs_ready !== 1'b1 || bus.out_decoder_rs_value !== 32'hDEAD ||
        bus.out_decoder_rt_ready !== 1'b0) begin
      errors++;
      $display("FAIL bypass_hit rs=%0b/%h rt=%0b required rs=1/0000dead rt=0",
               bus.out_decoder_rs_ready, bus.out_decoder_rs_value, bus.out_decoder_rt_ready);
    end
    tick();
    cdb_off();
    #1;
    checks++;
    if (bus.out_decoder_rs_ready !== 1'b1 || bus.out_decoder_rs_value !== 32'hDEAD) begin
      errors++;
      $display("FAIL bypass_stored rs=%0b/%h required 1/0000dead",
               bus.out_decoder_rs_ready, bus.out_decoder_rs_value);
    end
    // Broadcast to a free tag is ignored and never reports ready.
    bus.in_decoder_rs_reorder = 4'd9;
    cdb(4'd9, 32'hBEEF, 1'b0, 32'h0);
    #1;
    checks++;
    if (bus.out_decoder_rs_ready !== 1'b0) begin
      errors++;
      $display("FAIL bypass_free_tag rs=%0b required 0", bus.out_decoder_rs_ready);
    end
    tick();
    cdb_off();
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    alloc(5'd10, 1'b0);
    alloc(5'd11, 1'b0);
    alloc(5'd1, 1'b0);
    push_reg(5'd10, 32'h1, 4'd0);
    push_reg(5'd11, 32'h2, 4'd1);
    e = '{st: 1'b0, fl: 1'b1, rd: 5'd1, val: 32'h104, tag: 4'd2, pc: 32'h200};
    exp_q.push_back(e);
    cdb(4'd0, 32'h1, 1'b0, 32'h0);
    tick();
    cdb(4'd1, 32'h2, 1'b0, 32'h0);
    tick();
    cdb(4'd2, 32'h104, 1'b1, 32'h200);
    tick();
    cdb_off();
    bus.in_decoder_enable = 1'b1;
    bus.in_decoder_rd     = 5'd9;
    #1;
    checks++;
    if (bus.out_flush_enable !== 1'b1 || bus.out_flush_pc !== 32'h200 ||
        bus.out_reg_commit_enable !== 1'b1 || bus.out_reg_rd_addr !== 5'd1) begin
      errors++;
      $display("FAIL flush_pulse fl=%0b pc=%h reg=%0b rd=%0d required 1/00000200/1/1",
               bus.out_flush_enable, bus.out_flush_pc, bus.out_reg_commit_enable,
               bus.out_reg_rd_addr);
    end
    tick();
    bus.in_decoder_enable     = 1'b0;
    bus.in_decoder_rs_reorder = 4'd2;
    #1;
    checks++;
    if (bus.out_decoder_reorder !== 4'd0 || bus.out_decoder_full !== 1'b0 ||
        bus.out_flush_enable !== 1'b0 || bus.out_decoder_rs_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_after tail=%0d full=%0b fl=%0b rs=%0b required 0/0/0/0",
               bus.out_decoder_reorder, bus.out_decoder_full, bus.out_flush_enable,
               bus.out_decoder_rs_ready);
    end
    drain("flush");
  endtask

  task automatic test_store_gate();
    exp_t e;
    do_reset();
    alloc(5'd0, 1'b1);
    alloc(5'd3, 1'b0);
    cdb(4'd0, 32'h0, 1'b0, 32'h0);
    tick();
    cdb_off();
    in_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.out_lsb_store_commit !== 1'b0 || bus.out_reg_commit_enable !== 1'b0) begin
        errors++;
        $display("FAIL store_gated st=%0b reg=%0b required 0/0",
                 bus.out_lsb_store_commit, bus.out_reg_commit_enable);
      end
      tick();
    end
    e = '{st: 1'b1, fl: 1'b0, rd: 5'd0, val: 32'h0, tag: 4'd0, pc: 32'h0};
    exp_q.push_back(e);
    in_rdy = 1'b1;
    #1;
    checks++;
    if (bus.out_lsb_store_commit !== 1'b1 || bus.out_reg_commit_enable !== 1'b0 ||
        bus.out_lsb_reorder !== 4'd0) begin
      errors++;
      $display("FAIL store_release st=%0b reg=%0b tag=%0d required 1/0/0",
               bus.out_lsb_store_commit, bus.out_reg_commit_enable, bus.out_lsb_reorder);
    end
    tick();
    checks++;
    if (bus.out_lsb_store_commit !== 1'b0 || bus.out_reg_reorder !== 4'd1) begin
      errors++;
      $display("FAIL store_once st=%0b head=%0d required 0/1",
               bus.out_lsb_store_commit, bus.out_reg_reorder);
    end
    drain("store");
  endtask

  task automatic test_back_to_back();
    pend_t      pend[$];
    logic [3:0] tail_m = 4'd0;
    int         seq = 0;
    int         cyc = 0;
    do_reset();
    while ((seq < 40 || pend.size() != 0) && cyc < 600) begin
      checks++;
      if (bus.out_decoder_reorder !== tail_m) begin
        errors++;
        $display("FAIL b2b_tail got=%0d required %0d", bus.out_decoder_reorder, tail_m);
      end
      cdb_off();
      if (pend.size() != 0 && $urandom_range(0, 2) != 0) begin
        int    idx;
        pend_t p;
        idx = $urandom_range(0, pend.size() - 1);
        p   = pend[idx];
        pend.delete(idx);
        cdb(p.tag, p.val, 1'b0, 32'h0);
      end
      bus.in_decoder_enable = 1'b0;
      if (seq < 40 && $urandom_range(0, 1) != 0) begin
        bus.in_decoder_enable = 1'b1;
        bus.in_decoder_rd     = 5'(seq);
        if (!bus.out_decoder_full) begin
          pend_t p;
          p.tag = tail_m;
          p.val = 32'(seq * 3 + 1);
          push_reg(5'(seq), p.val, tail_m);
          pend.push_back(p);
          tail_m = tail_m + 4'd1;
          seq++;
        end
      end
      tick();
      cyc++;
    end
    cdb_off();
    bus.in_decoder_enable = 1'b0;
    checks++;
    if (seq != 40 || pend.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout seq=%0d pending=%0d required 40/0", seq, pend.size());
    end
    drain("b2b");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alloc();
    test_cdb_order();
    test_full();
    test_bypass();
    test_flush();
    test_store_gate();
    test_back_to_back();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
